jpeg_bitpack: RTL
=================

// Module: jpeg_bitpack
// PURPOSE
// - Encoder-side counterpart of the decoder's 96-bit register/unstuff front end.
// - Packs variable-width Huffman/amplitude codes MSB-first into a byte stream and inserts 0x00 after every 0xFF data byte.
// - Emits 32-bit words with the first byte in DataOut[7:0], the same word byte order the decoder input consumes.
// - On flush, pads to a byte boundary with 1s, optionally appends an unstuffed 0xFF/marker pair, then releases the partial last word.
// PARAMETERS
// - CODE_W    32   max code width; CodeWidth carries 1..CODE_W
// - ACC_W     64   bit accumulator width (must be >= 2*CODE_W)
// PORTS
// - rst           in   1   asynchronous, active-low reset
// - clk           in   1   clock
// - CodeIn        in  32   code, right-justified in CodeIn[CodeWidth-1:0], MSB sent first
// - CodeWidth     in   6   number of valid bits, 1..32; 0 = accepted but no bits
// - CodeValid     in   1   code present
// - CodeReady     out  1   code accepted this cycle when CodeValid & CodeReady
// - FlushReq      in   1   one-cycle pulse: end of scan
// - MarkerEn      in   1   sampled with FlushReq: append marker after padding
// - Marker        in   8   marker code (e.g. 8'hD9), sampled with FlushReq
// - FlushDone     out  1   one-cycle pulse after the last word is read
// - DataOut       out 32   output word, byte0 in [7:0]
// - DataOutBytes  out  3   valid bytes in DataOut: 1..4, from [7:0] upward
// - DataOutLast   out  1   word is the final word of the flush
// - DataOutEnable out  1   output word valid
// - DataOutRead   in   1   consumer takes the word this cycle (valid & read)
// BEHAVIOUR
// - Reset values:
//   - CodeReady=1, FlushDone=0, DataOut=0, DataOutBytes=0, DataOutLast=0, DataOutEnable=0.
//   - All internal state is cleared. Reset mid-operation discards pending bits and bytes without emitting anything.
// - Accumulator AccData[63:0] / AccWidth[6:0], MSB-aligned.
//   - CodeReady = (state==RUN) & (AccWidth <= 32) & ~FlushPending. It is combinational, like the decoder's DataInRead.
// - Byte stage, at most one byte per cycle:
//   - If AccWidth>=8, the stuff slot is free and the packer can accept, pop AccData[63:56] and shift left by 8.
//   - Accepting a code and popping a byte in the same cycle: AccWidth <= AccWidth + CodeWidth - 8.
//   - The new code is placed after the shift.
// - Stuffing: a popped 0xFF sets StuffPend. The next packer slot is forced to 8'h00 and no accumulator pop happens that cycle.
// - Packer:
//   - PackReg collects bytes into lanes 0..3.
//   - When 4 bytes are held and the output register is empty, or is read this cycle, transfer to DataOut with DataOutBytes=4.
//   - Otherwise the packer stalls, then the byte stage stalls, then CodeReady drops.
//   - No byte is ever lost or duplicated.
// - Output register:
//   - DataOut, DataOutBytes and DataOutLast are stable while DataOutEnable=1 and DataOutRead=0.
//   - Valid & read with a new word ready gives back-to-back transfer with no bubble.
// - FSM: RUN -> DRAIN -> PAD -> MARK_FF -> MARK_CODE -> LAST -> DONE -> RUN.
//   - RUN: FlushReq latches MarkerEn and Marker, sets FlushPending, goes to DRAIN.
//   - A code accepted in the same cycle as FlushReq belongs to the scan.
//   - FlushReq while not in RUN is ignored.
//   - DRAIN: wait until AccWidth<8 and StuffPend=0.
//   - PAD: if AccWidth>0, pad with 1s to 8 bits and pop that byte, stuffed if 0xFF. Then go to MARK_FF if MarkerEn, else LAST.
//   - MARK_FF / MARK_CODE: push 8'hFF, then Marker, both unstuffed.
//   - LAST: transfer PackReg with DataOutBytes = fill count and DataOutLast=1.
//   - Empty PackReg: no word is emitted, FlushDone fires directly, and DataOutLast is never seen.
//   - DONE: FlushDone=1 for one cycle after the last word is read; return to RUN with PackReg empty.
// - Unused bytes of a partial word are 8'h00.
// - Throughput: one byte per cycle. A 32-bit code costs 4 cycles plus 1 cycle per stuffed byte.
// STRUCTURE
// - Shared package jpeg_pkg: JPEG_MARKER_PREFIX=8'hFF, JPEG_STUFF=8'h00, JPEG_EOI=8'hD9; FSM state encodings.
// - One sub-module: jpeg_bitpack_word, the byte-to-word packer plus output register with the DataOutRead handshake.
// - The accumulator, stuffing and FSM stay in the top module.
// TESTING
// - Codes 4'hA, 4'hB, 8'h12, 16'h3456, DataOutRead=1 -> one word 32'h563412AB, Bytes=4, Last=0.
// - Codes 8'hFF, 24'h123456 -> word 32'h341200FF; flush without marker -> word 32'h00000056, Bytes=1, Last=1, then FlushDone.
// - Code 3'b101, flush without marker -> pad byte 8'hBF -> 32'h000000BF, Bytes=1, Last=1.
// - Code 8'hFF, flush with Marker=8'hD9 -> 32'hD9FF00FF, Bytes=4, Last=1; the marker FF is not stuffed.
// - Continuous 32-bit codes 32'hFFFFFFFF with DataOutRead=0 for 12 cycles:
//   - CodeReady falls and DataOut holds.
//   - After release the stream is strictly FF,00 repeated, in order.
// - rst low for 1 cycle while in PAD -> all outputs at reset values; a fresh code 8'h5A then flush -> 32'h0000005A, Bytes=1.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG constants and the bit packer's flush sequencing states.
package jpeg_pkg;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_STUFF         = 8'h00;
  localparam logic [7:0] JPEG_EOI           = 8'hD9;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_PAD,
    ST_MARK_FF,
    ST_MARK_CODE,
    ST_LAST,
    ST_DONE
  } packState_t;

  // Fill the unused low bits of a partial byte with 1s; used holds 1..7 valid MSBs.
  function automatic logic [7:0] padByte(input logic [7:0] partial, input logic [2:0] used);
    return partial | (8'hFF >> used);
  endfunction

endpackage

// File: rtl/jpeg_bitpack_word.sv
// Collects bytes into 32-bit words (first byte in [7:0]) and holds them in an
// output register until the consumer reads them.
module jpeg_bitpack_word (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  input  logic        lastReq,
  output logic        byteReady,
  output logic        lastTaken,
  input  logic        DataOutRead,
  output logic [31:0] DataOut,
  output logic [2:0]  DataOutBytes,
  output logic        DataOutLast,
  output logic        DataOutEnable
);

  logic [31:0] packReg;
  logic [2:0]  packCount;
  logic        outFree;
  logic        fullXfer;
  logic        lastXfer;
  logic        xfer;
  logic        bytePush;

  // A full word moves out only outside LAST so the flush can tag its final word.
  always_comb begin
    outFree   = ~DataOutEnable | DataOutRead;
    fullXfer  = ~lastReq & (packCount == 3'd4) & outFree;
    lastXfer  = lastReq & (packCount != 3'd0) & outFree;
    xfer      = fullXfer | lastXfer;
    byteReady = ~lastReq & ((packCount != 3'd4) | fullXfer);
    bytePush  = byteValid & byteReady;
    lastTaken = lastReq & ((packCount == 3'd0) | outFree);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      packReg       <= '0;
      packCount     <= '0;
      DataOut       <= '0;
      DataOutBytes  <= '0;
      DataOutLast   <= 1'b0;
      DataOutEnable <= 1'b0;
    end else begin
      if (xfer) begin
        DataOut       <= packReg;
        DataOutBytes  <= packCount;
        DataOutLast   <= lastXfer;
        DataOutEnable <= 1'b1;
      end else if (DataOutRead) begin
        DataOutEnable <= 1'b0;
      end

      if (xfer) begin
        packReg   <= bytePush ? {24'h0, byteIn} : '0;
        packCount <= bytePush ? 3'd1 : 3'd0;
      end else if (bytePush) begin
        packReg[{packCount[1:0], 3'b000} +: 8] <= byteIn;
        packCount <= packCount + 3'd1;
      end
    end
  end

endmodule

// File: rtl/jpeg_bitpack.sv
// JPEG entropy-coder back end: packs variable-width codes MSB-first, stuffs
// 0x00 after data 0xFF, and on flush pads, optionally appends a marker, and ends the scan.
module jpeg_bitpack
  import jpeg_pkg::*;
#(
  parameter int CODE_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CODE_W-1:0]       CodeIn,
  input  logic [$clog2(CODE_W):0] CodeWidth,
  input  logic                    CodeValid,
  output logic                    CodeReady,
  input  logic                    FlushReq,
  input  logic                    MarkerEn,
  input  logic [7:0]              Marker,
  output logic                    FlushDone,
  output logic [31:0]             DataOut,
  output logic [2:0]              DataOutBytes,
  output logic                    DataOutLast,
  output logic                    DataOutEnable,
  input  logic                    DataOutRead
);

  localparam int AW_W = $clog2(ACC_W) + 1;
  localparam logic [AW_W-1:0] BYTE_BITS = AW_W'(8);
  localparam logic [AW_W-1:0] ROOM_BITS = AW_W'(ACC_W - CODE_W);

  packState_t       state, stateNext;
  logic [ACC_W-1:0] accData, accShifted, codePlaced;
  logic [AW_W-1:0]  accWidth, widthAfterPop, codeBits, placeShift;
  logic [CODE_W-1:0] codeMasked;
  logic             stuffPend, flushPending, markerEnReg;
  logic [7:0]       markerReg, pushData, padValue;
  logic             pushValid, popByte, padPop, setStuff, clrStuff;
  logic             latchFlush, clearFlush, lastReq, flushDone, codeAccept;
  logic             byteReady, lastTaken;

  assign lastReq   = (state == ST_LAST);
  assign CodeReady = (state == ST_RUN) & (accWidth <= ROOM_BITS) & ~flushPending;
  assign codeAccept = CodeValid & CodeReady;
  assign FlushDone = flushDone;

  // New code lands right below whatever is left after this cycle's byte pop.
  always_comb begin
    codeBits = (CodeWidth > ($clog2(CODE_W)+1)'(CODE_W)) ? AW_W'(CODE_W) : AW_W'(CodeWidth);
    if (codeBits >= AW_W'(CODE_W)) begin
      codeMasked = CodeIn;
    end else begin
      codeMasked = CodeIn & ((CODE_W'(1) << codeBits) - CODE_W'(1));
    end
    widthAfterPop = popByte ? accWidth - BYTE_BITS : accWidth;
    accShifted    = popByte ? accData << 8 : accData;
    placeShift    = AW_W'(ACC_W) - widthAfterPop - codeBits;
    codePlaced    = ACC_W'(codeMasked) << placeShift;
  end

  // Byte source selection and flush sequencing; a pending stuff byte always goes first.
  always_comb begin
    stateNext  = state;
    pushValid  = 1'b0;
    pushData   = JPEG_STUFF;
    popByte    = 1'b0;
    padPop     = 1'b0;
    setStuff   = 1'b0;
    clrStuff   = 1'b0;
    latchFlush = 1'b0;
    clearFlush = 1'b0;
    flushDone  = 1'b0;
    padValue   = padByte(accData[ACC_W-1 -: 8], accWidth[2:0]);

    if (stuffPend) begin
      pushValid = byteReady;
      clrStuff  = byteReady;
    end

    unique case (state)
      ST_RUN, ST_DRAIN: begin
        if (!stuffPend && accWidth >= BYTE_BITS && byteReady) begin
          popByte   = 1'b1;
          pushValid = 1'b1;
          pushData  = accData[ACC_W-1 -: 8];
          setStuff  = (accData[ACC_W-1 -: 8] == JPEG_MARKER_PREFIX);
        end
        if (state == ST_RUN) begin
          if (FlushReq) begin
            latchFlush = 1'b1;
            stateNext  = ST_DRAIN;
          end
        end else if (accWidth < BYTE_BITS && !stuffPend) begin
          stateNext = ST_PAD;
        end
      end
      ST_PAD: begin
        if (!stuffPend) begin
          if (accWidth != '0) begin
            if (byteReady) begin
              padPop    = 1'b1;
              pushValid = 1'b1;
              pushData  = padValue;
              setStuff  = (padValue == JPEG_MARKER_PREFIX);
            end
          end else begin
            stateNext = markerEnReg ? ST_MARK_FF : ST_LAST;
          end
        end
      end
      ST_MARK_FF: begin
        if (byteReady) begin
          pushValid = 1'b1;
          pushData  = JPEG_MARKER_PREFIX;
          stateNext = ST_MARK_CODE;
        end
      end
      ST_MARK_CODE: begin
        if (byteReady) begin
          pushValid = 1'b1;
          pushData  = markerReg;
          stateNext = ST_LAST;
        end
      end
      ST_LAST: begin
        if (lastTaken) stateNext = ST_DONE;
      end
      ST_DONE: begin
        if (!DataOutEnable) begin
          flushDone  = 1'b1;
          clearFlush = 1'b1;
          stateNext  = ST_RUN;
        end
      end
      default: stateNext = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accData      <= '0;
      accWidth     <= '0;
      stuffPend    <= 1'b0;
      flushPending <= 1'b0;
      markerEnReg  <= 1'b0;
      markerReg    <= '0;
    end else begin
      if (padPop) begin
        accData  <= '0;
        accWidth <= '0;
      end else begin
        accData  <= accShifted | (codeAccept ? codePlaced : '0);
        accWidth <= widthAfterPop + (codeAccept ? codeBits : '0);
      end

      if (setStuff)      stuffPend <= 1'b1;
      else if (clrStuff) stuffPend <= 1'b0;

      if (latchFlush) begin
        flushPending <= 1'b1;
        markerEnReg  <= MarkerEn;
        markerReg    <= Marker;
      end else if (clearFlush) begin
        flushPending <= 1'b0;
      end
    end
  end

  jpeg_bitpack_word wordStage (
    .clk           (clk),
    .rst           (rst),
    .byteIn        (pushData),
    .byteValid     (pushValid),
    .lastReq       (lastReq),
    .byteReady     (byteReady),
    .lastTaken     (lastTaken),
    .DataOutRead   (DataOutRead),
    .DataOut       (DataOut),
    .DataOutBytes  (DataOutBytes),
    .DataOutLast   (DataOutLast),
    .DataOutEnable (DataOutEnable)
  );

endmodule
